// File: rtl/text_renderer.sv
// Character-cell pixel renderer: maps char/scheme/coordinates to RGB222 through a
// two-stage pipeline with programmable palette, integer scaling and blinking cursor.

module bitmap_rom #(
  parameter int CHAR_W = 5
) (
  input  logic [CHAR_W-1:0] i_char,
  input  logic [2:0]        i_cy,
  input  logic [2:0]        i_cx,
  output logic              o_dot
);

  // Glyph 0 is blank and glyph 1 is solid; the rest are simple test patterns.
  always_comb begin
    o_dot = 1'b0;
    case (i_char)
      CHAR_W'(0): o_dot = 1'b0;
      CHAR_W'(1): o_dot = 1'b1;
      CHAR_W'(2): o_dot = i_cx[0] ^ i_cy[0];
      CHAR_W'(3): o_dot = (i_cx == 3'd0);
      CHAR_W'(4): o_dot = (i_cy == 3'd0);
      default:    o_dot = (i_cx == i_cy) ^ i_char[0];
    endcase
  end

endmodule

module text_renderer #(
  parameter int CHAR_W     = 5,
  parameter int N_SCHEMES  = 4,
  parameter int SCALE_LOG2 = 0,
  parameter int BLINK_LOG2 = 4,
  localparam int SW        = $clog2(N_SCHEMES)
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_valid,
  input  logic [CHAR_W-1:0] i_char,
  input  logic [SW-1:0]     i_color,
  input  logic [10:0]       i_x,
  input  logic [10:0]       i_y,
  input  logic [5:0]        i_rgb,
  input  logic              i_sel,
  input  logic              i_frame,
  input  logic              i_cur_en,
  input  logic [7:0]        i_cur_col,
  input  logic [7:0]        i_cur_row,
  input  logic              i_pal_we,
  input  logic [SW-1:0]     i_pal_addr,
  input  logic [5:0]        i_pal_fg,
  input  logic [5:0]        i_pal_bg,
  output logic [5:0]        o_video,
  output logic              o_valid
);

  function automatic logic [5:0] pal_rst_fg(input int idx);
    case (idx)
      1, 2, 3: return 6'b000000;
      default: return 6'b111111;
    endcase
  endfunction

  function automatic logic [5:0] pal_rst_bg(input int idx);
    case (idx)
      1:       return 6'b011101;
      2:       return 6'b110001;
      default: return 6'b000000;
    endcase
  endfunction

  logic [5:0]          pal_fg_q [N_SCHEMES];
  logic [5:0]          pal_fg_d [N_SCHEMES];
  logic [5:0]          pal_bg_q [N_SCHEMES];
  logic [5:0]          pal_bg_d [N_SCHEMES];
  logic [BLINK_LOG2:0] blink_q, blink_d;

  logic              vld_p1_q, vld_p1_d;
  logic              sel_p1_q, sel_p1_d;
  logic [5:0]        rgb_p1_q, rgb_p1_d;
  logic [CHAR_W-1:0] char_p1_q, char_p1_d;
  logic [2:0]        cx_p1_q, cx_p1_d;
  logic [2:0]        cy_p1_q, cy_p1_d;
  logic [5:0]        fg_p1_q, fg_p1_d;
  logic [5:0]        bg_p1_q, bg_p1_d;
  logic              hit_p1_q, hit_p1_d;

  logic [5:0]        video_p2_q, video_p2_d;
  logic              vld_p2_q, vld_p2_d;

  logic [10:0]       cell_col, cell_row;
  logic              dot_p1;
  logic [5:0]        fg_eff, bg_eff;

  always_comb begin
    pal_fg_d = pal_fg_q;
    pal_bg_d = pal_bg_q;
    if (i_pal_we) begin
      pal_fg_d[i_pal_addr] = i_pal_fg;
      pal_bg_d[i_pal_addr] = i_pal_bg;
    end
    blink_d = i_frame ? blink_q + (BLINK_LOG2+1)'(1) : blink_q;
  end

  // Stage 1: cell decode, palette read and cursor hit against the pre-increment phase
  assign cell_col = i_x >> (SCALE_LOG2 + 3);
  assign cell_row = i_y >> (SCALE_LOG2 + 3);

  always_comb begin
    vld_p1_d  = i_valid;
    sel_p1_d  = i_sel;
    rgb_p1_d  = i_rgb;
    char_p1_d = i_char;
    cx_p1_d   = i_x[SCALE_LOG2 +: 3];
    cy_p1_d   = i_y[SCALE_LOG2 +: 3];
    fg_p1_d   = pal_fg_q[i_color];
    bg_p1_d   = pal_bg_q[i_color];
    hit_p1_d  = i_cur_en & ~blink_q[BLINK_LOG2]
              & (cell_col == {3'b000, i_cur_col})
              & (cell_row == {3'b000, i_cur_row});
  end

  // Stage 2: glyph lookup, cursor swap and output priority
  bitmap_rom #(CHAR_W) u_rom (
    .i_char (char_p1_q),
    .i_cy   (cy_p1_q),
    .i_cx   (cx_p1_q),
    .o_dot  (dot_p1)
  );

  always_comb begin
    fg_eff     = hit_p1_q ? bg_p1_q : fg_p1_q;
    bg_eff     = hit_p1_q ? fg_p1_q : bg_p1_q;
    vld_p2_d   = vld_p1_q;
    video_p2_d = 6'b000000;
    if (vld_p1_q) begin
      if (sel_p1_q)    video_p2_d = rgb_p1_q;
      else if (dot_p1) video_p2_d = fg_eff;
      else             video_p2_d = bg_eff;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int i = 0; i < N_SCHEMES; i++) begin
        pal_fg_q[i] <= pal_rst_fg(i);
        pal_bg_q[i] <= pal_rst_bg(i);
      end
      blink_q    <= '0;
      vld_p1_q   <= 1'b0;
      sel_p1_q   <= 1'b0;
      rgb_p1_q   <= '0;
      char_p1_q  <= '0;
      cx_p1_q    <= '0;
      cy_p1_q    <= '0;
      fg_p1_q    <= '0;
      bg_p1_q    <= '0;
      hit_p1_q   <= 1'b0;
      video_p2_q <= '0;
      vld_p2_q   <= 1'b0;
    end else begin
      pal_fg_q   <= pal_fg_d;
      pal_bg_q   <= pal_bg_d;
      blink_q    <= blink_d;
      vld_p1_q   <= vld_p1_d;
      sel_p1_q   <= sel_p1_d;
      rgb_p1_q   <= rgb_p1_d;
      char_p1_q  <= char_p1_d;
      cx_p1_q    <= cx_p1_d;
      cy_p1_q    <= cy_p1_d;
      fg_p1_q    <= fg_p1_d;
      bg_p1_q    <= bg_p1_d;
      hit_p1_q   <= hit_p1_d;
      video_p2_q <= video_p2_d;
      vld_p2_q   <= vld_p2_d;
    end
  end

  assign o_video = video_p2_q;
  assign o_valid = vld_p2_q;

endmodule

// File: tb/tb_text_renderer.sv
// Bench for text_renderer: default instance plus a scaled/fast-blink instance on shared stimulus.

module tb_text_renderer;

  logic        i_clk;
  logic        i_rst_n;
  logic        i_valid;
  logic [4:0]  i_char;
  logic [1:0]  i_color;
  logic [10:0] i_x, i_y;
  logic [5:0]  i_rgb;
  logic        i_sel;
  logic        i_frame;
  logic        i_cur_en;
  logic [7:0]  i_cur_col, i_cur_row;
  logic        i_pal_we;
  logic [1:0]  i_pal_addr;
  logic [5:0]  i_pal_fg, i_pal_bg;
  logic [5:0]  video0, video1;
  logic        valid0, valid1;

  int n_chk;
  int n_bad;

  logic [5:0] pal_fg_m [4];
  logic [5:0] pal_bg_m [4];
  int bc0, bc1;

  text_renderer u_dut0 (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_valid(i_valid), .i_char(i_char),
    .i_color(i_color), .i_x(i_x), .i_y(i_y), .i_rgb(i_rgb), .i_sel(i_sel),
    .i_frame(i_frame), .i_cur_en(i_cur_en), .i_cur_col(i_cur_col),
    .i_cur_row(i_cur_row), .i_pal_we(i_pal_we), .i_pal_addr(i_pal_addr),
    .i_pal_fg(i_pal_fg), .i_pal_bg(i_pal_bg), .o_video(video0), .o_valid(valid0)
  );

  text_renderer #(.SCALE_LOG2(1), .BLINK_LOG2(1)) u_dut1 (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_valid(i_valid), .i_char(i_char),
    .i_color(i_color), .i_x(i_x), .i_y(i_y), .i_rgb(i_rgb), .i_sel(i_sel),
    .i_frame(i_frame), .i_cur_en(i_cur_en), .i_cur_col(i_cur_col),
    .i_cur_row(i_cur_row), .i_pal_we(i_pal_we), .i_pal_addr(i_pal_addr),
    .i_pal_fg(i_pal_fg), .i_pal_bg(i_pal_bg), .o_video(video1), .o_valid(valid1)
  );

  initial begin
    i_clk = 1'b0;
    forever #5 i_clk = ~i_clk;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_chk++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", tag, got, want);
    end
  endtask

  task automatic step;
    @(posedge i_clk);
    #1;
  endtask

  task automatic idle;
    i_valid = 1'b0; i_sel = 1'b0; i_rgb = '0; i_char = '0; i_color = '0;
    i_x = '0; i_y = '0; i_frame = 1'b0; i_cur_en = 1'b0; i_cur_col = '0;
    i_cur_row = '0; i_pal_we = 1'b0; i_pal_addr = '0; i_pal_fg = '0; i_pal_bg = '0;
  endtask

  task automatic do_reset;
    i_rst_n = 1'b0;
    idle();
    pal_fg_m = '{6'h3F, 6'h00, 6'h00, 6'h00};
    pal_bg_m = '{6'h00, 6'h1D, 6'h31, 6'h00};
    bc0 = 0;
    bc1 = 0;
    step();
    step();
    i_rst_n = 1'b1;
    step();
  endtask

  // Present the current inputs for one cycle, then idle until the pixel reaches the output.
  task automatic render;
    step();
    i_valid = 1'b0; i_sel = 1'b0; i_pal_we = 1'b0; i_frame = 1'b0;
    step();
  endtask

  task automatic px(input int x, input int y);
    i_x = 11'(x);
    i_y = 11'(y);
    i_valid = 1'b1;
    render();
  endtask

  function automatic bit glyph_m(input int c, input int cy, input int cx);
    case (c)
      0:       return 1'b0;
      1:       return 1'b1;
      2:       return ((cx ^ cy) & 1) != 0;
      3:       return cx == 0;
      4:       return cy == 0;
      default: return (cx == cy) != ((c & 1) != 0);
    endcase
  endfunction

  function automatic logic [6:0] ref_pix(input int s, input bit ph);
    int cx, cy, ccol, crow;
    logic [5:0] fg, bg, t;
    bit hit, dot;
    cx   = (int'(i_x) >> s) & 7;
    cy   = (int'(i_y) >> s) & 7;
    ccol = int'(i_x) >> (s + 3);
    crow = int'(i_y) >> (s + 3);
    hit  = i_cur_en && ph && (ccol == int'(i_cur_col)) && (crow == int'(i_cur_row));
    fg   = pal_fg_m[i_color];
    bg   = pal_bg_m[i_color];
    if (hit) begin t = fg; fg = bg; bg = t; end
    dot  = glyph_m(int'(i_char), cy, cx);
    if (!i_valid) return 7'd0;
    if (i_sel) return {1'b1, i_rgb};
    return {1'b1, dot ? fg : bg};
  endfunction

  initial begin
    logic [6:0] e0_prev, e1_prev, e0_cur, e1_cur;
    logic [5:0] exp0, exp1;
    bit inv;
    n_chk = 0;
    n_bad = 0;
    idle();
    i_rst_n = 1'b1;
    #3 i_rst_n = 1'b0;
    #1;
    check("rst_vid0", video0, 6'h00);
    check("rst_vld0", valid0, 1'b0);
    check("rst_vid1", video1, 6'h00);
    do_reset();

    // Scheme 1, blank glyph: background color after two edges
    i_char = 5'd0; i_color = 2'd1;
    px(0, 0);
    check("bg_s1_vid0", video0, 6'h1D);
    check("bg_s1_vld0", valid0, 1'b1);
    check("bg_s1_vid1", video1, 6'h1D);

    // Asynchronous reset mid-stream
    i_valid = 1'b1;
    step();
    step();
    check("pre_rst_vid0", video0, 6'h1D);
    i_rst_n = 1'b0;
    #2;
    check("async_rst_vid0", video0, 6'h00);
    check("async_rst_vld0", valid0, 1'b0);
    check("async_rst_vid1", video1, 6'h00);
    check("async_rst_vld1", valid1, 1'b0);
    step();
    step();
    i_rst_n = 1'b1;
    step();
    check("rst_lat1_vld0", valid0, 1'b0);
    step();
    check("rst_lat2_vld0", valid0, 1'b1);
    check("rst_lat2_vid0", video0, 6'h1D);
    i_valid = 1'b0;
    step();
    step();

    // Palette write and read on the same edge sees the old entry
    i_pal_we = 1'b1; i_pal_addr = 2'd2; i_pal_fg = 6'h2A; i_pal_bg = 6'h15;
    i_char = 5'd1; i_color = 2'd2;
    px(0, 0);
    check("pal_same_edge", video0, 6'h00);
    i_char = 5'd1;
    px(0, 0);
    check("pal_new_fg", video0, 6'h2A);
    i_char = 5'd0;
    px(0, 0);
    check("pal_new_bg", video1, 6'h15);

    // Overlay select wins on active pixels, blanking wins otherwise
    i_char = 5'd1; i_color = 2'd0; i_sel = 1'b1; i_rgb = 6'h33;
    px(0, 0);
    check("ovl_vid0", video0, 6'h33);
    i_sel = 1'b1; i_rgb = 6'h33;
    step();
    step();
    check("ovl_blank_vid0", video0, 6'h00);
    check("ovl_blank_vld0", valid0, 1'b0);
    i_sel = 1'b0;

    // Reset restores the palette
    do_reset();
    i_char = 5'd1; i_color = 2'd2;
    px(0, 0);
    check("pal_rst_fg", video0, 6'h00);
    i_char = 5'd0; i_color = 2'd2;
    px(0, 0);
    check("pal_rst_bg", video0, 6'h31);

    // Horizontal sweep with checker glyph and cursor on cell (1,0)
    do_reset();
    i_cur_en = 1'b1; i_cur_col = 8'd1; i_cur_row = 8'd0;
    i_char = 5'd2; i_color = 2'd0; i_y = 11'd0;
    for (int i = 0; i <= 32; i++) begin
      i_valid = (i < 32);
      i_x = 11'(i);
      step();
      if (i >= 1) begin
        int xp;
        xp = i - 1;
        exp1 = ((((xp >> 1) & 1) != 0) != ((xp >> 4) == 1)) ? 6'h3F : 6'h00;
        exp0 = (((xp & 1) != 0) != ((xp >> 3) == 1)) ? 6'h3F : 6'h00;
        check("sweep_s1", video1, exp1);
        check("sweep_s0", video0, exp0);
      end
    end
    i_valid = 1'b0;
    step();

    // Cursor blink on cell (3,2): period of four frames on the fast instance
    do_reset();
    i_cur_en = 1'b1; i_cur_col = 8'd3; i_cur_row = 8'd2;
    i_char = 5'd2; i_color = 2'd0;
    for (int f = 0; f <= 4; f++) begin
      inv = (f % 4) < 2;
      px(48, 32);
      check("cur_bg", video1, inv ? 6'h3F : 6'h00);
      px(50, 32);
      check("cur_fg", video1, inv ? 6'h00 : 6'h3F);
      px(64, 32);
      check("nbr_bg", video1, 6'h00);
      px(66, 32);
      check("nbr_fg", video1, 6'h3F);
      px(24, 16);
      check("cur_s0", video0, 6'h3F);
      check("cur_s0_other", video1, 6'h00);
      i_frame = 1'b1;
      px(48, 32);
      check("cur_frame_edge", video1, inv ? 6'h3F : 6'h00);
    end

    // Random stream against the reference model
    do_reset();
    e0_prev = 7'd0;
    e1_prev = 7'd0;
    for (int k = 0; k < 1000; k++) begin
      i_valid    = ($urandom_range(0, 7) != 0);
      i_sel      = ($urandom_range(0, 7) == 0);
      i_rgb      = 6'($urandom);
      i_char     = 5'($urandom_range(0, 31));
      i_color    = 2'($urandom);
      i_x        = 11'($urandom_range(0, 127));
      i_y        = 11'($urandom_range(0, 63));
      i_cur_en   = ($urandom_range(0, 3) != 0);
      i_cur_col  = 8'($urandom_range(0, 7));
      i_cur_row  = 8'($urandom_range(0, 3));
      i_frame    = ($urandom_range(0, 15) == 0);
      i_pal_we   = ($urandom_range(0, 15) == 0);
      i_pal_addr = 2'($urandom);
      i_pal_fg   = 6'($urandom);
      i_pal_bg   = 6'($urandom);
      e0_cur = ref_pix(0, bc0 < 16);
      e1_cur = ref_pix(1, bc1 < 2);
      step();
      if (i_pal_we) begin
        pal_fg_m[i_pal_addr] = i_pal_fg;
        pal_bg_m[i_pal_addr] = i_pal_bg;
      end
      if (i_frame) begin
        bc0 = (bc0 + 1) % 32;
        bc1 = (bc1 + 1) % 4;
      end
      check("rnd_vid0", video0, e0_prev[5:0]);
      check("rnd_vld0", valid0, e0_prev[6]);
      check("rnd_vid1", video1, e1_prev[5:0]);
      check("rnd_vld1", valid1, e1_prev[6]);
      e0_prev = e0_cur;
      e1_prev = e1_cur;
    end
    idle();
    step();
    check("rnd_last_vid0", video0, e0_prev[5:0]);
    check("rnd_last_vid1", video1, e1_prev[5:0]);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
